// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file slave: FSM state encoding,
// wait-counter width and the byte-lane helper.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StDone
  } apb_state_e;

  // Wide enough for the largest wait-state count (15)
  localparam int unsigned WaitCntW = 4;

  // Number of low address bits that select a byte within one data word
  function automatic int unsigned addr_lsbs(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Down-counter that times the PREADY-low cycles of one APB access.
// o_done flags the last wait cycle so the FSM can move to DONE on that edge.
module apb_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on every new access, otherwise count down while waiting
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave exposing NUM_REGS DATA_W-bit registers with byte strobes,
// configurable wait states and an error response for bad addresses.
// SETUP is the bus setup phase; it is recognised combinationally from
// PSEL & !PENABLE so the access phase lasts exactly WAIT_CYCLES+1 cycles.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        NUM_REGS    = 8,
  parameter int unsigned        WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PRWADDR,
  input  logic [DATA_W-1:0]   PRWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRWDATA1,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int unsigned       Lsb     = addr_lsbs(DATA_W);
  localparam int unsigned       NumB    = DATA_W / 8;
  localparam int unsigned       IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] LsbMask = ADDR_W'((1 << Lsb) - 1);

  apb_state_e        r_state;
  apb_state_e        w_cur;
  apb_state_e        w_next;
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [IdxW-1:0]   r_idx;
  logic              r_err;
  logic              r_write;
  logic              r_ready;
  logic              r_slverr;
  logic [DATA_W-1:0] r_rdata;

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_idx_full;
  logic [IdxW-1:0]   w_dec_idx;
  logic              w_dec_err;
  logic [IdxW-1:0]   w_fin_idx;
  logic              w_fin_err;
  logic              w_fin_write;
  logic              w_load;
  logic              w_cnt_en;
  logic              w_cnt_done;

  // Address decode of the bus address currently presented
  always_comb begin
    w_off      = PRWADDR - BASE_ADDR;
    w_idx_full = w_off >> Lsb;
    w_dec_idx  = w_idx_full[IdxW-1:0];
    w_dec_err  = (PRWADDR < BASE_ADDR) || ((w_off & LsbMask) != '0) ||
                 (w_idx_full >= ADDR_W'(NUM_REGS));
  end

  // Current phase, next state and the access attributes used on entry to DONE
  always_comb begin
    w_cur = r_state;
    if ((r_state == StIdle || r_state == StDone) && PSEL && !PENABLE) begin
      w_cur = StSetup;
    end
    w_next = StIdle;
    unique case (w_cur)
      StIdle:  w_next = StIdle;
      StSetup: w_next = (WAIT_CYCLES > 0) ? StWait : StDone;
      StWait: begin
        if (!PSEL)           w_next = StIdle;
        else if (w_cnt_done) w_next = StDone;
        else                 w_next = StWait;
      end
      StDone:  w_next = StIdle;
      default: w_next = StIdle;
    endcase
    // With zero wait states DONE follows SETUP directly, before r_idx is latched
    w_fin_idx   = (w_cur == StSetup) ? w_dec_idx : r_idx;
    w_fin_err   = (w_cur == StSetup) ? w_dec_err : r_err;
    w_fin_write = (w_cur == StSetup) ? PWRITE    : r_write;
    w_load      = (w_cur == StSetup) && (w_next == StWait);
    w_cnt_en    = (r_state == StWait);
  end

  apb_wait_counter #(
    .CNT_W (WaitCntW)
  ) u_wait_counter (
    .i_clk      (PCLK),
    .i_rst      (PRESET),
    .i_load     (w_load),
    .i_load_val (WaitCntW'(WAIT_CYCLES)),
    .i_en       (w_cnt_en),
    .o_done     (w_cnt_done)
  );

  // FSM state, latched access attributes and registered bus responses
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_cur == StSetup) begin
        r_idx   <= w_dec_idx;
        r_err   <= w_dec_err;
        r_write <= PWRITE;
      end
      r_ready  <= (w_next == StDone);
      r_slverr <= (w_next == StDone) && w_fin_err;
      r_rdata  <= ((w_next == StDone) && !w_fin_err && !w_fin_write) ? r_mem[w_fin_idx] : '0;
    end
  end

  // Register file: byte-strobed write committed on the DONE edge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if ((r_state == StDone) && r_write && !r_err) begin
      for (int b = 0; b < NumB; b++) begin
        if (PSTRB[b]) r_mem[r_idx][8*b +: 8] <= PRWDATA[8*b +: 8];
      end
    end
  end

  assign PREADY   = r_ready;
  assign PSLVERR  = r_slverr;
  assign PRWDATA1 = r_rdata;

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the data bus width (8, 16 or 32).
REQ-002 The block SHALL have parameter ADDR_W, default 32, the address bus width.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, the number of DATA_W registers (1..256).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 1, the number of PREADY-low access cycles (0..15).
REQ-005 The block SHALL have parameter BASE_ADDR, default 0, the byte address of register 0.
REQ-006 The block SHALL have port PCLK, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port PRESET, input, 1 bit, the reset, synchronous and active-high.
REQ-008 The block SHALL have port PSEL, input, 1 bit, slave select.
REQ-009 The block SHALL have port PENABLE, input, 1 bit, access-phase flag.
REQ-010 The block SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have port PRWADDR, input, ADDR_W bits, byte address.
REQ-012 The block SHALL have port PRWDATA, input, DATA_W bits, write data.
REQ-013 The block SHALL have port PSTRB, input, DATA_W/8 bits, byte write strobes.
REQ-014 The block SHALL have port PRWDATA1, output, DATA_W bits, read data.
REQ-015 The block SHALL have port PREADY, output, 1 bit, transfer complete.
REQ-016 The block SHALL have port PSLVERR, output, 1 bit, error response.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, SETUP, WAIT and DONE.
REQ-018 FSM transitions SHALL be: IDLE->SETUP on PSEL&!PENABLE; SETUP->WAIT on PENABLE when WAIT_CYCLES>0, else SETUP->DONE; WAIT->DONE after WAIT_CYCLES cycles; DONE->SETUP if PSEL&!PENABLE, else DONE->IDLE.
REQ-019 PREADY SHALL be 1 only in DONE, so an access phase lasts exactly WAIT_CYCLES+1 cycles.
REQ-020 The register index SHALL be (PRWADDR-BASE_ADDR)>>log2(DATA_W/8), latched in SETUP.
REQ-021 An access SHALL be erroneous if the address is below BASE_ADDR, the index is >= NUM_REGS, or the low address bits are nonzero (misaligned).
REQ-022 A write SHALL commit on the DONE edge only, updating each byte whose PSTRB bit is 1; erroneous writes SHALL NOT modify any register.
REQ-023 PRWDATA1 SHALL carry the indexed register in DONE for a valid read, and 0 otherwise (writes, errors, non-DONE states).
REQ-024 PSLVERR SHALL be 1 only in DONE of an erroneous access, and 0 in all other cycles.
REQ-025 If PSEL deasserts in SETUP or WAIT, the FSM SHALL return to IDLE next cycle with no write and no PREADY.
REQ-026 PENABLE=1 with PSEL=0 SHALL be ignored; PENABLE=1 in IDLE SHALL NOT start a transfer.
REQ-027 The wait counter SHALL reload at every SETUP->WAIT transition, so back-to-back transfers each get full WAIT_CYCLES.

Reset
REQ-028 When PRESET is sampled high, the FSM SHALL go to IDLE, all registers and the wait counter SHALL clear to 0, and PREADY, PSLVERR and PRWDATA1 SHALL be 0 from the next edge.
REQ-029 PRESET SHALL take priority over any in-flight transfer, which is aborted without write.

Structure
REQ-030 A shared package apb_pkg SHALL hold the FSM state enum and the function computing the address LSB count from DATA_W.
REQ-031 The wait-state counter SHALL be a sub-module apb_wait_counter (load, count-down, done flag); the register file and decode SHALL stay in apb_regfile_slave.

Verification
REQ-032 Defaults, write 15 to 0x4 with PSTRB=0xF, then read 0x4 -> PREADY high in the 2nd access cycle; read PRWDATA1=15; PSLVERR=0.
REQ-033 Write 0xAABBCCDD to 0x8 with PSTRB=0x5 over prior 0 -> read returns 0x00BB00DD.
REQ-034 Write to 0x20 (index 8) and to 0x6 (misaligned) -> PSLVERR=1 with PREADY; read-back of all registers is unchanged.
REQ-035 WAIT_CYCLES=0 and WAIT_CYCLES=3 -> PREADY after 1 and 4 access cycles respectively; back-to-back transfers each have the same latency.
REQ-036 PSEL dropped in WAIT, and PRESET asserted in WAIT -> no PREADY, target register unchanged (0 after reset), FSM back in IDLE.
